// File: rtl/reflet_vga_rect_fill_pkg.sv
// Shared VGA geometry: font cell size and helpers that derive coordinate
// widths and maximum coordinates from the screen size and bit reduction.
package reflet_vga_rect_fill_pkg;

  localparam int FONT_WIDTH  = 8;
  localparam int FONT_HEIGHT = 16;

  function automatic int coord_width(input int size, input int reduction);
    return $clog2(size) - reduction;
  endfunction

  function automatic int coord_max(input int size, input int reduction);
    return (size >> reduction) - 1;
  endfunction

endpackage

// File: rtl/reflet_vga_rect_fill.sv
// Rectangle filler: accepts a corner pair and colour, then streams one bitmap
// pixel write per cycle in row-major order, ending with a one-cycle done pulse.
module reflet_vga_rect_fill
  import reflet_vga_rect_fill_pkg::*;
#(
  parameter int h_size        = 640,
  parameter int v_line        = 480,
  parameter int color_depth   = 8,
  parameter int bit_reduction = 0,
  localparam int HW = coord_width(h_size, bit_reduction),
  localparam int VW = coord_width(v_line, bit_reduction)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [HW-1:0]          x0,
  input  logic [HW-1:0]          x1,
  input  logic [VW-1:0]          y0,
  input  logic [VW-1:0]          y1,
  input  logic [color_depth-1:0] R_in,
  input  logic [color_depth-1:0] G_in,
  input  logic [color_depth-1:0] B_in,
  input  logic [color_depth-1:0] a_in,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  output logic                   write_bitmap,
  output logic [HW-1:0]          h_pixel,
  output logic [VW-1:0]          v_pixel,
  output logic [color_depth-1:0] R_out,
  output logic [color_depth-1:0] G_out,
  output logic [color_depth-1:0] B_out,
  output logic [color_depth-1:0] a_out,
  output logic                   busy,
  output logic                   done
);

  localparam logic [HW-1:0] HMAX = HW'(coord_max(h_size, bit_reduction));
  localparam logic [VW-1:0] VMAX = VW'(coord_max(v_line, bit_reduction));

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t        state;
  logic [HW-1:0] x0_r;
  logic [HW-1:0] x1_r;
  logic [VW-1:0] y1_r;

  logic [HW-1:0] x1_clamped;
  logic [VW-1:0] y1_clamped;
  logic          empty_rect;

  // Far corner is clamped onto the screen; anything still inverted or fully
  // off-screen becomes an empty command that goes straight to DONE.
  always_comb begin
    x1_clamped = x1;
    y1_clamped = y1;
    if (x1 > HMAX) x1_clamped = HMAX;
    if (y1 > VMAX) y1_clamped = VMAX;
    empty_rect = (x0 > HMAX) || (y0 > VMAX) ||
                 (x0 > x1_clamped) || (y0 > y1_clamped);
  end

  // The pixel counters are the h_pixel/v_pixel outputs themselves; end tests
  // are equality against the stored far corner so Hmax/Vmax never overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cmd_ready    <= 1'b0;
      write_bitmap <= 1'b0;
      done         <= 1'b0;
      busy         <= 1'b0;
      h_pixel      <= '0;
      v_pixel      <= '0;
      R_out        <= '0;
      G_out        <= '0;
      B_out        <= '0;
      a_out        <= '0;
      x0_r         <= '0;
      x1_r         <= '0;
      y1_r         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            x0_r      <= x0;
            x1_r      <= x1_clamped;
            y1_r      <= y1_clamped;
            R_out     <= R_in;
            G_out     <= G_in;
            B_out     <= B_in;
            a_out     <= a_in;
            if (empty_rect) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state        <= FILL;
              write_bitmap <= 1'b1;
              h_pixel      <= x0;
              v_pixel      <= y0;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        FILL: begin
          if (h_pixel == x1_r) begin
            if (v_pixel == y1_r) begin
              state        <= DONE;
              write_bitmap <= 1'b0;
              done         <= 1'b1;
            end else begin
              h_pixel <= x0_r;
              v_pixel <= v_pixel + VW'(1);
            end
          end else begin
            h_pixel <= h_pixel + HW'(1);
          end
        end

        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end

        default: begin
          state        <= IDLE;
          write_bitmap <= 1'b0;
          done         <= 1'b0;
          busy         <= 1'b0;
          cmd_ready    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reflet_vga_rect_fill.sv
// Directed bench for reflet_vga_rect_fill: one task per scenario, all
// expected coordinates and timings computed by hand in the bench.
module tb_reflet_vga_rect_fill;

  localparam int HW = 10;
  localparam int VW = 9;
  localparam int CD = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [HW-1:0] x0 = '0;
  logic [HW-1:0] x1 = '0;
  logic [VW-1:0] y0 = '0;
  logic [VW-1:0] y1 = '0;
  logic [CD-1:0] R_in = '0;
  logic [CD-1:0] G_in = '0;
  logic [CD-1:0] B_in = '0;
  logic [CD-1:0] a_in = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          write_bitmap;
  logic [HW-1:0] h_pixel;
  logic [VW-1:0] v_pixel;
  logic [CD-1:0] R_out;
  logic [CD-1:0] G_out;
  logic [CD-1:0] B_out;
  logic [CD-1:0] a_out;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  reflet_vga_rect_fill dut (
    .clk(clk), .reset(reset),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1),
    .R_in(R_in), .G_in(G_in), .B_in(B_in), .a_in(a_in),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .write_bitmap(write_bitmap), .h_pixel(h_pixel), .v_pixel(v_pixel),
    .R_out(R_out), .G_out(G_out), .B_out(B_out), .a_out(a_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic set_cmd(input int ax0, input int ay0, input int ax1, input int ay1,
                         input logic [CD-1:0] r, input logic [CD-1:0] g,
                         input logic [CD-1:0] b, input logic [CD-1:0] a);
    x0 = HW'(ax0); y0 = VW'(ay0); x1 = HW'(ax1); y1 = VW'(ay1);
    R_in = r; G_in = g; B_in = b; a_in = a;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, write_bitmap, done, busy} !== 4'b0 || h_pixel !== '0 || v_pixel !== '0 ||
        {R_out, G_out, B_out, a_out} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: ready=%b wr=%b done=%b busy=%b h=%0d v=%0d col=%h, required all 0",
               cmd_ready, write_bitmap, done, busy, h_pixel, v_pixel, {R_out, G_out, B_out, a_out});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release_ready: ready=%b busy=%b, required 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_basic_fill;
    @(negedge clk);
    set_cmd(2, 3, 4, 4, 8'h11, 8'h22, 8'h33, 8'hFF);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int v = 3; v <= 4; v++) begin
      for (int h = 2; h <= 4; h++) begin
        checks++;
        if (write_bitmap !== 1'b1 || h_pixel !== HW'(h) || v_pixel !== VW'(v) || busy !== 1'b1 ||
            {R_out, G_out, B_out, a_out} !== 32'h112233FF) begin
          errors++;
          $display("[TB] FAIL basic_write: wr=%b h=%0d v=%0d busy=%b col=%h, required 1 %0d %0d 1 112233ff",
                   write_bitmap, h_pixel, v_pixel, busy, {R_out, G_out, B_out, a_out}, h, v);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (done !== 1'b1 || write_bitmap !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_done: done=%b wr=%b ready=%b busy=%b, required 1 0 0 1",
               done, write_bitmap, cmd_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_idle: done=%b busy=%b ready=%b, required 0 0 1", done, busy, cmd_ready);
    end
  endtask

  // 900 does not fit the 9-bit y port, so 500 stands in as the off-screen row.
  task automatic test_clamp;
    int writes;
    writes = 0;
    @(negedge clk);
    set_cmd(630, 470, 700, 500, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int v = 470; v <= 479; v++) begin
      for (int h = 630; h <= 639; h++) begin
        if (write_bitmap === 1'b1) writes++;
        checks++;
        if (write_bitmap !== 1'b1 || h_pixel !== HW'(h) || v_pixel !== VW'(v)) begin
          errors++;
          $display("[TB] FAIL clamp_write: wr=%b h=%0d v=%0d, required 1 %0d %0d",
                   write_bitmap, h_pixel, v_pixel, h, v);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (writes != 100 || done !== 1'b1 || write_bitmap !== 1'b0 || h_pixel !== 10'd639 || v_pixel !== 9'd479) begin
      errors++;
      $display("[TB] FAIL clamp_end: writes=%0d done=%b wr=%b h=%0d v=%0d, required 100 1 0 639 479",
               writes, done, write_bitmap, h_pixel, v_pixel);
    end
    @(negedge clk);
    checks++;
    if (write_bitmap !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clamp_idle: wr=%b ready=%b, required 0 1", write_bitmap, cmd_ready);
    end
  endtask

  task automatic test_empty;
    @(negedge clk);
    set_cmd(5, 5, 4, 9, 8'h01, 8'h02, 8'h03, 8'h04);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || write_bitmap !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL empty_done: done=%b wr=%b busy=%b, required 1 0 1", done, write_bitmap, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || write_bitmap !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL empty_idle: done=%b wr=%b ready=%b, required 0 0 1", done, write_bitmap, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_fill;
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    set_cmd(0, 0, 9, 0, 8'h55, 8'h66, 8'h77, 8'h88);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (write_bitmap !== 1'b1 || h_pixel !== 10'd2) begin
      errors++;
      $display("[TB] FAIL rst_third_write: wr=%b h=%0d, required 1 2", write_bitmap, h_pixel);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (write_bitmap !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0 || h_pixel !== '0) begin
      errors++;
      $display("[TB] FAIL rst_async: wr=%b done=%b busy=%b ready=%b h=%0d, required all 0",
               write_bitmap, done, busy, cmd_ready, h_pixel);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1 || write_bitmap === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_after_release: done_or_write_cycles=%0d ready=%b, required 0 1", done_seen, cmd_ready);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    set_cmd(1, 1, 2, 1, 8'hC1, 8'hC2, 8'hC3, 8'hC4);
    cmd_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (write_bitmap !== 1'b1 || h_pixel !== 10'd1 || v_pixel !== 9'd1 || R_out !== 8'hC1) begin
      errors++;
      $display("[TB] FAIL b2b_a_first: wr=%b h=%0d v=%0d R=%h, required 1 1 1 c1", write_bitmap, h_pixel, v_pixel, R_out);
    end
    set_cmd(5, 6, 5, 6, 8'hD1, 8'hD2, 8'hD3, 8'hD4);
    @(negedge clk);
    checks++;
    if (write_bitmap !== 1'b1 || h_pixel !== 10'd2 || v_pixel !== 9'd1 || R_out !== 8'hC1 || a_out !== 8'hC4) begin
      errors++;
      $display("[TB] FAIL b2b_a_second: wr=%b h=%0d v=%0d R=%h a=%h, required 1 2 1 c1 c4",
               write_bitmap, h_pixel, v_pixel, R_out, a_out);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_a_done: done=%b ready=%b, required 1 0", done, cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || write_bitmap !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_gap: ready=%b wr=%b busy=%b, required 1 0 0", cmd_ready, write_bitmap, busy);
    end
    @(negedge clk);
    checks++;
    if (write_bitmap !== 1'b1 || h_pixel !== 10'd5 || v_pixel !== 9'd6 || R_out !== 8'hD1 || cmd_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_b_write: wr=%b h=%0d v=%0d R=%h ready=%b, required 1 5 6 d1 0",
               write_bitmap, h_pixel, v_pixel, R_out, cmd_ready);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || write_bitmap !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_b_done: done=%b wr=%b, required 1 0", done, write_bitmap);
    end
    @(negedge clk);
  endtask

  task automatic test_single_pixel;
    int writes;
    int busy_cycles;
    writes = 0;
    busy_cycles = 0;
    @(negedge clk);
    set_cmd(0, 0, 0, 0, 8'h0F, 8'hF0, 8'h3C, 8'hC3);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (write_bitmap === 1'b1) writes++;
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
    end
    checks++;
    if (writes != 1 || busy_cycles != 2) begin
      errors++;
      $display("[TB] FAIL single_pixel: writes=%0d busy_cycles=%0d, required 1 2", writes, busy_cycles);
    end
  endtask

  initial begin
    test_reset;
    test_basic_fill;
    test_clamp;
    test_empty;
    test_reset_mid_fill;
    test_back_to_back;
    test_single_pixel;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
